tank_sensor_model: RTL
======================

Name: tank_sensor_model

Overview:
Behavioural-synthesizable plant model of the water tank. It takes the pump commands B1/B2 and produces the lower/upper level sensor signals I/S that the tank controller consumes, which closes the control loop for simulation and FPGA bring-up. It integrates tank level per tick from pump inflow and an external drain rate, applies sensor hysteresis, supports fault injection (including the inconsistent I=0/S=1 reading), and keeps sticky overflow/dry flags.

Parameters:
LEVEL_W, 8, level register width
MAX_LEVEL, 255, tank capacity; must be < 2^LEVEL_W
INIT_LEVEL, 128, level loaded on reset
LOW_TH, 64, lower sensor threshold
HIGH_TH, 192, upper sensor threshold
HYST, 4, hysteresis; constraints: HYST < LOW_TH and HIGH_TH - HYST > LOW_TH
PUMP_RATE, 3, level units added per running pump per tick
TICK_DIV, 4, clk cycles per level update; must be >= 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
B1  in  1  pump 1 running
B2  in  1  pump 2 running
drain  in  LEVEL_W  level units removed per tick (consumption)
fault_mode  in  2  00 none, 01 I stuck 0, 10 S stuck 1, 11 both stuck 0
flag_clr  in  1  clears overflow/dry
I  out  1  lower sensor (1 = water at/above lower sensor)
S  out  1  upper sensor (1 = water at/above upper sensor)
level  out  LEVEL_W  current tank level
overflow  out  1  sticky: inflow exceeded MAX_LEVEL
dry  out  1  sticky: drain exceeded available level
tick  out  1  one-cycle pulse on each level update

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port named reset. All state is cleared immediately on reset assertion, mid-operation included.
- Reset values: level=INIT_LEVEL, tick counter=0, tick=0, overflow=0, dry=0. Zone is derived from INIT_LEVEL without hysteresis (>=HIGH_TH: HIGH, >=LOW_TH: MID, else LOW). I/S take the values for that zone; with defaults, I=1 and S=0.
- Tick counter: counts 0..TICK_DIV-1 and wraps. The registered tick output is 1 in the cycle after the counter equals TICK_DIV-1. The first tick occurs TICK_DIV cycles after reset release.
- Level update, on the cycles where the counter is at TICK_DIV-1:
  - sum = level + PUMP_RATE*(B1+B2) - drain, computed signed at LEVEL_W+3 bits with no truncation.
  - level <= clamp(sum, 0, MAX_LEVEL).
  - sum > MAX_LEVEL sets overflow; sum < 0 sets dry.
  - B1/B2/drain are sampled only in that cycle.
- Flags: sticky. flag_clr clears both. When a set and flag_clr occur in the same cycle, the set wins.
- Zone FSM, evaluated every cycle on the registered level:
  - LOW: I=0, S=0. MID: I=1, S=0. HIGH: I=1, S=1.
  - LOW->HIGH if level>=HIGH_TH, else LOW->MID if level>=LOW_TH.
  - MID->HIGH if level>=HIGH_TH; MID->LOW if level<LOW_TH-HYST.
  - HIGH->LOW if level<LOW_TH-HYST, else HIGH->MID if level<HIGH_TH-HYST.
  - Otherwise hold.
- Latency: level changes on the tick edge; the zone updates 1 cycle later. I/S are registered from the zone plus fault_mode, so I/S follow the level 2 cycles after the update.
- Fault overrides are applied in the I/S output register (1-cycle latency) and do not affect level or zone. Mode 10 in zone MID/HIGH yields I=1, S=1; in LOW it yields I=0, S=1, the inconsistent reading.

Decomposition:
- Shared package tank_pkg:
  - zone encoding (ZONE_LOW=2'b00, ZONE_MID=2'b01, ZONE_HIGH=2'b11), matching the controller's EMTPY/HALF/FULL sensor patterns.
  - fault_mode codes.
- Sub-module tank_level_acc: tick counter, signed add/clamp, overflow/dry flag generation.
- Top level: zone FSM and sensor output register.

Test Plan:
- Reset check, defaults: after reset, level=128, I=1, S=0, overflow=0, dry=0. tick pulses at cycles 4, 8, 12, ... after reset release.
- Fill: B1=B2=1, drain=0 from 128, +6 per tick.
  - Tick 11 gives level=194; S goes to 1 two cycles later.
  - Tick 21 gives 254; tick 22 gives level=255 and overflow=1.
- Hysteresis: from 194, B1=B2=0, drain=2.
  - Level 190 and 188 keep S=1.
  - Level 186 drops S to 0.
  - Later, I drops only when level reaches 58 (<60), not at 62.
- Dry and clear: level=5, drain=10, no pumps → level=0, dry=1. flag_clr in the same cycle as another dry event leaves dry=1; flag_clr alone clears it.
- Faults at level 200 (zone HIGH):
  - fault_mode=01 → I=0, S=1 one cycle later; back to 00 → I=1, S=1.
  - fault_mode=11 → I=0, S=0.
- Async reset mid-fill at level 170: assert reset between edges → level=128, I=1, S=0, tick=0 immediately. After release, the first tick comes 4 cycles later.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared encodings for the tank plant model: sensor zones and fault-injection codes.
package tank_pkg;

    localparam int unsigned FAULT_W = 2;

    // Zone codes double as the {S, I} sensor pattern the controller expects.
    typedef enum logic [1:0] {
        ZONE_LOW  = 2'b00,
        ZONE_MID  = 2'b01,
        ZONE_HIGH = 2'b11
    } zone_e;

    typedef enum logic [FAULT_W-1:0] {
        FAULT_NONE        = 2'b00,
        FAULT_I_STUCK0    = 2'b01,
        FAULT_S_STUCK1    = 2'b10,
        FAULT_BOTH_STUCK0 = 2'b11
    } fault_e;

    // Zone of a level without hysteresis; used for the reset state.
    function automatic zone_e zone_of(input int unsigned lvl,
                                      input int unsigned low_th,
                                      input int unsigned high_th);
        if (lvl >= high_th)     return ZONE_HIGH;
        else if (lvl >= low_th) return ZONE_MID;
        else                    return ZONE_LOW;
    endfunction

endpackage

// File: rtl/tank_sensor_model_if.sv
// Pump/drain/fault inputs and sensor/level/flag outputs of the tank plant model.
interface tank_sensor_model_if #(
    parameter int unsigned LEVEL_W = 8
);
    logic               B1;
    logic               B2;
    logic [LEVEL_W-1:0] drain;
    logic [1:0]         fault_mode;
    logic               flag_clr;
    logic               I;
    logic               S;
    logic [LEVEL_W-1:0] level;
    logic               overflow;
    logic               dry;
    logic               tick;

    modport master (
        output B1, B2, drain, fault_mode, flag_clr,
        input  I, S, level, overflow, dry, tick
    );

    modport slave (
        input  B1, B2, drain, fault_mode, flag_clr,
        output I, S, level, overflow, dry, tick
    );
endinterface

// File: rtl/tank_level_acc.sv
// Tick divider plus per-tick level integration with clamping and sticky overflow/dry flags.
module tank_level_acc #(
    parameter int unsigned LEVEL_W    = 8,
    parameter int unsigned MAX_LEVEL  = 255,
    parameter int unsigned INIT_LEVEL = 128,
    parameter int unsigned PUMP_RATE  = 3,
    parameter int unsigned TICK_DIV   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               b1_i,
    input  logic               b2_i,
    input  logic [LEVEL_W-1:0] drain_i,
    input  logic               flag_clr_i,
    output logic [LEVEL_W-1:0] level_o,
    output logic               overflow_o,
    output logic               dry_o,
    output logic               tick_o
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SUM_W = LEVEL_W + 3;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LEVEL_W-1:0]      level_q, level_d;
    logic                    overflow_q, overflow_d;
    logic                    dry_q, dry_d;
    logic                    tick_q, tick_d;
    logic                    upd;
    logic signed [SUM_W-1:0] inflow;
    logic signed [SUM_W-1:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            level_q    <= LEVEL_W'(INIT_LEVEL);
            overflow_q <= 1'b0;
            dry_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            dry_q      <= dry_d;
            tick_q     <= tick_d;
        end
    end

    // Sum is wide enough that neither overfill nor overdrain wraps before clamping.
    always_comb begin
        upd        = (cnt_q == CNT_W'(TICK_DIV - 1));
        cnt_d      = upd ? '0 : cnt_q + 1'b1;
        tick_d     = upd;
        inflow     = signed'(SUM_W'(PUMP_RATE) * (SUM_W'(b1_i) + SUM_W'(b2_i)));
        sum        = signed'(SUM_W'(level_q)) + inflow - signed'(SUM_W'(drain_i));
        level_d    = level_q;
        overflow_d = overflow_q;
        dry_d      = dry_q;

        if (flag_clr_i) begin
            overflow_d = 1'b0;
            dry_d      = 1'b0;
        end

        // A flag set in the same cycle as a clear must survive, so it is applied last.
        if (upd) begin
            if (sum > signed'(SUM_W'(MAX_LEVEL))) begin
                level_d    = LEVEL_W'(MAX_LEVEL);
                overflow_d = 1'b1;
            end else if (sum[SUM_W-1]) begin
                level_d = '0;
                dry_d   = 1'b1;
            end else begin
                level_d = sum[LEVEL_W-1:0];
            end
        end
    end

    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign dry_o      = dry_q;
    assign tick_o     = tick_q;

endmodule

// File: rtl/tank_sensor_model.sv
// Water tank plant model: integrates level from pump commands and produces hysteretic I/S sensors.
module tank_sensor_model
    import tank_pkg::*;
#(
    parameter int unsigned LEVEL_W    = 8,
    parameter int unsigned MAX_LEVEL  = 255,
    parameter int unsigned INIT_LEVEL = 128,
    parameter int unsigned LOW_TH     = 64,
    parameter int unsigned HIGH_TH    = 192,
    parameter int unsigned HYST       = 4,
    parameter int unsigned PUMP_RATE  = 3,
    parameter int unsigned TICK_DIV   = 4
) (
    input logic                clk,
    input logic                reset,
    tank_sensor_model_if.slave bus
);

    localparam int unsigned LOW_EXIT  = LOW_TH - HYST;
    localparam int unsigned HIGH_EXIT = HIGH_TH - HYST;
    localparam zone_e       ZONE_INIT = zone_of(INIT_LEVEL, LOW_TH, HIGH_TH);
    localparam logic        I_INIT    = (ZONE_INIT != ZONE_LOW);
    localparam logic        S_INIT    = (ZONE_INIT == ZONE_HIGH);

    logic [LEVEL_W-1:0] acc_level;
    logic               acc_overflow;
    logic               acc_dry;
    logic               acc_tick;
    zone_e              zone_q, zone_d;
    logic               i_q, i_d;
    logic               s_q, s_d;

    tank_level_acc #(
        .LEVEL_W    (LEVEL_W),
        .MAX_LEVEL  (MAX_LEVEL),
        .INIT_LEVEL (INIT_LEVEL),
        .PUMP_RATE  (PUMP_RATE),
        .TICK_DIV   (TICK_DIV)
    ) u_acc (
        .clk        (clk),
        .reset      (reset),
        .b1_i       (bus.B1),
        .b2_i       (bus.B2),
        .drain_i    (bus.drain),
        .flag_clr_i (bus.flag_clr),
        .level_o    (acc_level),
        .overflow_o (acc_overflow),
        .dry_o      (acc_dry),
        .tick_o     (acc_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zone_q <= ZONE_INIT;
            i_q    <= I_INIT;
            s_q    <= S_INIT;
        end else begin
            zone_q <= zone_d;
            i_q    <= i_d;
            s_q    <= s_d;
        end
    end

    // Zone transitions with hysteresis on the way down; sensors follow the registered zone.
    always_comb begin
        zone_d = zone_q;
        i_d    = 1'b0;
        s_d    = 1'b0;

        case (zone_q)
            ZONE_LOW: begin
                if (acc_level >= LEVEL_W'(HIGH_TH))     zone_d = ZONE_HIGH;
                else if (acc_level >= LEVEL_W'(LOW_TH)) zone_d = ZONE_MID;
            end
            ZONE_MID: begin
                if (acc_level >= LEVEL_W'(HIGH_TH))      zone_d = ZONE_HIGH;
                else if (acc_level < LEVEL_W'(LOW_EXIT)) zone_d = ZONE_LOW;
            end
            ZONE_HIGH: begin
                if (acc_level < LEVEL_W'(LOW_EXIT))       zone_d = ZONE_LOW;
                else if (acc_level < LEVEL_W'(HIGH_EXIT)) zone_d = ZONE_MID;
            end
            default: zone_d = ZONE_LOW;
        endcase

        i_d = (zone_q != ZONE_LOW);
        s_d = (zone_q == ZONE_HIGH);

        // Faults only distort what the sensors report, never the level or zone.
        case (fault_e'(bus.fault_mode))
            FAULT_I_STUCK0: i_d = 1'b0;
            FAULT_S_STUCK1: s_d = 1'b1;
            FAULT_BOTH_STUCK0: begin
                i_d = 1'b0;
                s_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.I        = i_q;
    assign bus.S        = s_q;
    assign bus.level    = acc_level;
    assign bus.overflow = acc_overflow;
    assign bus.dry      = acc_dry;
    assign bus.tick     = acc_tick;

endmodule
